// File: rtl/gsens_multi_draw.sv
// Frame-buffer draw source: centre crosshair plus one IIR-smoothed tilt mark per channel.
// Optional GSENS_GRID_EN adds a 32-pixel grid below the crosshair.
module gsens_multi_draw #(
  parameter int SOURCE_ID        = 0,
  parameter int SOURCE_SEL_ADDRW = 4,
  parameter int COLOR_DEPTH      = 9,
  parameter int DRAW_WIDTH       = 640,
  parameter int DRAW_HEIGHT      = 480,
  parameter int N_CH             = 2,
  parameter int MARK_SIZE        = 10,
  parameter int TILT_SCALE       = 1,
  parameter int SMOOTH_SHIFT     = 2,
  parameter logic [4*COLOR_DEPTH-1:0] MARK_COLORS = {4{9'h1c0}},
  parameter logic [COLOR_DEPTH-1:0]   CROSS_COLOR = 9'h1ff
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
  input  logic                        write_awaited,
  input  logic                        tilt_valid,
  // Each channel carries an X and a Y nibble, so the bus is 8 bits per channel.
  input  logic [8*N_CH-1:0]           tilt_amount,
  input  logic [2*N_CH-1:0]           tilt_direction,
  output logic                        write_active,
  output logic [COLOR_DEPTH-1:0]      write_color_data,
  output logic                        write_transparent,
  output logic [31:0]                 write_x_addr,
  output logic [31:0]                 write_y_addr,
  output logic                        frame_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SNAP   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int X_LIM = DRAW_WIDTH / 2 - MARK_SIZE - 1;
  localparam int Y_LIM = DRAW_HEIGHT / 2 - MARK_SIZE - 1;
  localparam int X_LO  = DRAW_WIDTH / 2 - 1 - MARK_SIZE;
  localparam int X_HI  = DRAW_WIDTH / 2 + MARK_SIZE;
  localparam int Y_LO  = DRAW_HEIGHT / 2 - 1 - MARK_SIZE;
  localparam int Y_HI  = DRAW_HEIGHT / 2 + MARK_SIZE;

  logic [1:0]  state;
  logic [31:0] col;
  logic [31:0] row;
  logic        granted;
  logic        owns_bus;
  logic        pix_hit;
  logic [COLOR_DEPTH-1:0] pix_color;

  logic signed [15:0] filt_x [N_CH];
  logic signed [15:0] filt_y [N_CH];
  logic signed [15:0] snap_x [N_CH];
  logic signed [15:0] snap_y [N_CH];

  // One IIR step toward the signed target, clamped so the mark stays inside the draw area.
  function automatic logic signed [15:0] filt_next(input logic signed [15:0] f,
                                                   input logic [3:0] amt,
                                                   input logic neg,
                                                   input int lim);
    logic signed [15:0] mag, tgt, nxt, lim16;
    mag   = $signed({12'd0, amt}) <<< TILT_SCALE;
    tgt   = neg ? -mag : mag;
    nxt   = f + ((tgt - f) >>> SMOOTH_SHIFT);
    lim16 = $signed(16'(lim));
    if (nxt > lim16)
      nxt = lim16;
    else if (nxt < -lim16)
      nxt = -lim16;
    return nxt;
  endfunction

  assign granted  = (write_source_sel == SOURCE_SEL_ADDRW'(SOURCE_ID));
  assign owns_bus = (state == S_ACTIVE) && granted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (write_awaited && granted) state <= S_SNAP;
        S_SNAP:
          if (!granted) begin
            state <= S_IDLE;
          end else begin
            state <= S_ACTIVE;
            col   <= '0;
            row   <= '0;
          end
        S_ACTIVE:
          if (!granted) begin
            state <= S_IDLE;
          end else if (col == 32'(DRAW_WIDTH - 1)) begin
            col <= '0;
            if (row == 32'(DRAW_HEIGHT - 1))
              state <= S_DONE;
            else
              row <= row + 32'd1;
          end else begin
            col <= col + 32'd1;
          end
        default:
          state <= S_IDLE;
      endcase
    end
  end

  // Filters follow every valid sample; snapshots freeze the marks for the coming frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        filt_x[k] <= '0;
        filt_y[k] <= '0;
        snap_x[k] <= '0;
        snap_y[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (tilt_valid) begin
          filt_x[k] <= filt_next(filt_x[k], tilt_amount[8*k +: 4], tilt_direction[2*k], X_LIM);
          filt_y[k] <= filt_next(filt_y[k], tilt_amount[8*k+4 +: 4], tilt_direction[2*k+1], Y_LIM);
        end
        if (state == S_SNAP) begin
          snap_x[k] <= filt_x[k];
          snap_y[k] <= filt_y[k];
        end
      end
    end
  end

  always_comb begin
    pix_hit   = 1'b0;
    pix_color = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!pix_hit &&
          $signed(col) >= X_LO + int'(snap_x[k]) && $signed(col) <= X_HI + int'(snap_x[k]) &&
          $signed(row) >= Y_LO + int'(snap_y[k]) && $signed(row) <= Y_HI + int'(snap_y[k])) begin
        pix_hit   = 1'b1;
        pix_color = MARK_COLORS[k*COLOR_DEPTH +: COLOR_DEPTH];
      end
    end
    if (!pix_hit &&
        (col == 32'(DRAW_WIDTH / 2 - 1) || col == 32'(DRAW_WIDTH / 2) ||
         row == 32'(DRAW_HEIGHT / 2 - 1) || row == 32'(DRAW_HEIGHT / 2))) begin
      pix_hit   = 1'b1;
      pix_color = CROSS_COLOR;
    end
`ifdef GSENS_GRID_EN
    if (!pix_hit && (col[4:0] == 5'd0 || row[4:0] == 5'd0)) begin
      pix_hit   = 1'b1;
      pix_color = COLOR_DEPTH'(9'h092);
    end
`endif
  end

  assign write_active      = owns_bus ? 1'b1 : 1'bz;
  assign write_transparent = owns_bus ? ~pix_hit : 1'bz;
  assign write_color_data  = (owns_bus && pix_hit) ? pix_color : {COLOR_DEPTH{1'bz}};
  assign write_x_addr      = owns_bus ? col : 32'bz;
  assign write_y_addr      = owns_bus ? row : 32'bz;
  assign frame_done        = (state == S_DONE);

endmodule

// File: tb/tb_gsens_multi_draw.sv
// Randomised bench for gsens_multi_draw against a pixel-level reference model.
// Honours GSENS_GRID_EN the same way the design does.
module tb_gsens_multi_draw;

  localparam int W      = 16;
  localparam int H      = 8;
  localparam int MS     = 1;
  localparam int NCH    = 2;
  localparam int SCALE  = 1;
  localparam int SS     = 2;
  localparam int SRC    = 2;
  localparam int NPIX   = W * H;
  localparam int XLIM   = W / 2 - MS - 1;
  localparam int YLIM   = H / 2 - MS - 1;
  localparam logic [35:0] MCOL  = {9'h0aa, 9'h155, 9'h038, 9'h1c0};
  localparam logic [8:0]  CCOL  = 9'h1ff;

  localparam int PH_IDLE = 0, PH_SNAP = 1, PH_ACTIVE = 2, PH_DONE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  write_source_sel;
  logic        write_awaited;
  logic        tilt_valid;
  logic [15:0] tilt_amount;
  logic [3:0]  tilt_direction;
  wire         write_active;
  wire  [8:0]  write_color_data;
  wire         write_transparent;
  wire  [31:0] write_x_addr;
  wire  [31:0] write_y_addr;
  wire         frame_done;

  int n_compared   = 0;
  int n_mismatched = 0;

  int phase, pix;
  int fx[NCH], fy[NCH], sx[NCH], sy[NCH];
  int seen_active, seen_done;

  gsens_multi_draw #(
    .SOURCE_ID(SRC), .SOURCE_SEL_ADDRW(4), .COLOR_DEPTH(9),
    .DRAW_WIDTH(W), .DRAW_HEIGHT(H), .N_CH(NCH), .MARK_SIZE(MS),
    .TILT_SCALE(SCALE), .SMOOTH_SHIFT(SS), .MARK_COLORS(MCOL), .CROSS_COLOR(CCOL)
  ) dut (
    .clk(clk), .reset(reset),
    .write_source_sel(write_source_sel), .write_awaited(write_awaited),
    .tilt_valid(tilt_valid), .tilt_amount(tilt_amount), .tilt_direction(tilt_direction),
    .write_active(write_active), .write_color_data(write_color_data),
    .write_transparent(write_transparent), .write_x_addr(write_x_addr),
    .write_y_addr(write_y_addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Moving a fraction 1/2^SS of the way to the target, rounding toward minus infinity.
  function automatic int model_filter(int f, int amt, bit neg, int lim);
    int tgt, d, div, q;
    tgt = amt * (1 << SCALE);
    if (neg) tgt = -tgt;
    d   = tgt - f;
    div = 1 << SS;
    q   = d / div;
    if (d < 0 && (d % div) != 0) q = q - 1;
    f = f + q;
    if (f > lim) f = lim;
    if (f < -lim) f = -lim;
    return f;
  endfunction

  task automatic expected_pixel(input int p, output bit hit, output logic [8:0] color);
    int c, r;
    c = p % W;
    r = p / W;
    hit = 1'b0;
    color = '0;
    for (int k = 0; k < NCH; k++)
      if (!hit && c >= W/2 - 1 - MS + sx[k] && c <= W/2 + MS + sx[k] &&
          r >= H/2 - 1 - MS + sy[k] && r <= H/2 + MS + sy[k]) begin
        hit = 1'b1;
        color = MCOL[k*9 +: 9];
      end
    if (!hit && (c == W/2 - 1 || c == W/2 || r == H/2 - 1 || r == H/2)) begin
      hit = 1'b1;
      color = CCOL;
    end
`ifdef GSENS_GRID_EN
    if (!hit && (c % 32 == 0 || r % 32 == 0)) begin
      hit = 1'b1;
      color = 9'h092;
    end
`endif
  endtask

  task automatic model_reset();
    phase = PH_IDLE;
    pix = 0;
    for (int k = 0; k < NCH; k++) begin
      fx[k] = 0; fy[k] = 0; sx[k] = 0; sy[k] = 0;
    end
  endtask

  task automatic model_step();
    bit granted;
    granted = (write_source_sel == 4'(SRC));
    case (phase)
      PH_IDLE:   if (write_awaited && granted) phase = PH_SNAP;
      PH_SNAP:   if (!granted) phase = PH_IDLE;
                 else begin
                   for (int k = 0; k < NCH; k++) begin sx[k] = fx[k]; sy[k] = fy[k]; end
                   phase = PH_ACTIVE;
                   pix = 0;
                 end
      PH_ACTIVE: if (!granted) phase = PH_IDLE;
                 else if (pix == NPIX - 1) phase = PH_DONE;
                 else pix++;
      default:   phase = PH_IDLE;
    endcase
    if (tilt_valid)
      for (int k = 0; k < NCH; k++) begin
        fx[k] = model_filter(fx[k], int'(tilt_amount[8*k +: 4]), tilt_direction[2*k], XLIM);
        fy[k] = model_filter(fy[k], int'(tilt_amount[8*k+4 +: 4]), tilt_direction[2*k+1], YLIM);
      end
  endtask

  // Drives one cycle at the falling edge, checks the bus, then advances the model.
  task automatic applyStimulus(input bit rst, input bit awaited, input logic [3:0] sel,
                               input bit tv, input logic [15:0] amt, input logic [3:0] dir);
    bit hit;
    logic [8:0] color;
    reset = rst;
    write_awaited = awaited;
    write_source_sel = sel;
    tilt_valid = tv;
    tilt_amount = amt;
    tilt_direction = dir;
    if (rst) model_reset();
    #1;
    checkOutput("frame_done", frame_done, (phase == PH_DONE));
    if (frame_done === 1'b1) seen_done++;
    if (write_active === 1'b1) seen_active++;
    if (phase == PH_ACTIVE && sel == 4'(SRC)) begin
      expected_pixel(pix, hit, color);
      checkOutput("active", write_active, 1'b1);
      checkOutput("x_addr", write_x_addr, 32'(pix % W));
      checkOutput("y_addr", write_y_addr, 32'(pix / W));
      checkOutput("transparent", write_transparent, !hit);
      checkOutput("color", write_color_data, hit ? color : 9'bz);
    end else begin
      checkOutput("active_z", write_active, 1'bz);
      checkOutput("x_addr_z", write_x_addr, 32'bz);
      checkOutput("y_addr_z", write_y_addr, 32'bz);
      checkOutput("transparent_z", write_transparent, 1'bz);
      checkOutput("color_z", write_color_data, 9'bz);
    end
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic hold_tilt(input logic [15:0] amt, input logic [3:0] dir, input int cycles);
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'b0, 1'b0, 4'(SRC + 1), 1'b1, amt, dir);
  endtask

  // Runs one granted frame; drop_at/reset_at pick the pixel at which to abort (-1 = never).
  task automatic run_frame(input bit rand_tilt, input bit rand_drop, input int drop_at,
                           input int reset_at);
    bit started, aborted, rst, tv;
    logic [3:0] sel;
    logic [15:0] amt;
    logic [3:0] dir;
    int budget;
    started = 0; aborted = 0; budget = 0;
    seen_active = 0; seen_done = 0;
    amt = '0; dir = '0; tv = 1'b0;
    while (!(started && phase == PH_IDLE) && budget < 400) begin
      sel = 4'(SRC);
      rst = 1'b0;
      if (rand_tilt) begin
        tv = 1'($urandom_range(0, 1));
        amt = 16'($urandom);
        dir = 4'($urandom);
      end
      if (phase == PH_ACTIVE && pix == drop_at) begin sel = 4'(SRC + 1); aborted = 1; end
      if (phase == PH_ACTIVE && pix == reset_at) begin rst = 1'b1; aborted = 1; end
      if (rand_drop && phase != PH_IDLE && $urandom_range(0, 299) == 0) begin
        sel = 4'(SRC + 1); aborted = 1;
      end
      if (phase != PH_IDLE) started = 1;
      applyStimulus(rst, 1'b1, sel, tv, amt, dir);
      budget++;
    end
    if (budget >= 400) checkOutput("frame_timeout", 1'b1, 1'b0);
    if (!aborted) begin
      checkOutput("active_cycles", 64'(seen_active), 64'(NPIX));
      checkOutput("done_pulses", 64'(seen_done), 64'd1);
    end else begin
      checkOutput("no_done_on_abort", 64'(seen_done), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    write_awaited = 1'b0;
    write_source_sel = '0;
    tilt_valid = 1'b0;
    tilt_amount = '0;
    tilt_direction = '0;
    model_reset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'(SRC), 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 4'(SRC), 1'b0, '0, '0);

    $display("[TB] centred marks and crosshair");
    run_frame(1'b0, 1'b0, -1, -1);

    $display("[TB] opposite X tilts on the two channels");
    hold_tilt(16'h0002 | 16'h0200, 4'b0100, 30);
    run_frame(1'b0, 1'b0, -1, -1);

    $display("[TB] clamped offsets");
    hold_tilt(16'hf00f, 4'b1000, 30);
    run_frame(1'b0, 1'b0, -1, -1);
    hold_tilt(16'h0ff0, 4'b0011, 30);
    run_frame(1'b0, 1'b0, -1, -1);

    $display("[TB] smoothing toward +8");
    hold_tilt(16'h0000, 4'b0000, 40);
    hold_tilt(16'h0004, 4'b0000, 6);
    run_frame(1'b0, 1'b0, -1, -1);

    $display("[TB] grant loss mid-frame then regrant");
    run_frame(1'b0, 1'b0, 40, -1);
    applyStimulus(1'b0, 1'b0, 4'(SRC + 1), 1'b0, '0, '0);
    run_frame(1'b0, 1'b0, -1, -1);

    $display("[TB] reset mid-frame");
    hold_tilt(16'h5a3c, 4'b0110, 10);
    run_frame(1'b0, 1'b0, -1, 60);
    applyStimulus(1'b0, 1'b0, 4'(SRC), 1'b0, '0, '0);
    run_frame(1'b0, 1'b0, -1, -1);

    $display("[TB] random frames");
    for (int f = 0; f < 14; f++) begin
      for (int i = 0; i < int'($urandom_range(0, 8)); i++)
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom));
      if (phase != PH_IDLE)
        for (int i = 0; i < 3 && phase != PH_IDLE; i++)
          applyStimulus(1'b0, 1'b0, 4'(SRC + 1), 1'b0, '0, '0);
      run_frame(1'b1, 1'b1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
